// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM/LSU stage: bus layouts, stall encoding,
// load/store type codes and LSU FSM states.
package mem_lsu_pkg;

  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_WD     = 6;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [STALL_WD-1:0] stall_bus_t;

  typedef enum logic [3:0] {
    LST_NONE = 4'b0000,
    LST_LB   = 4'b0001,
    LST_LBU  = 4'b0010,
    LST_LH   = 4'b0011,
    LST_LHU  = 4'b0100,
    LST_SB   = 4'b0101,
    LST_LW   = 4'b0110,
    LST_SH   = 4'b0111
  } ld_st_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_HOLD
  } lsu_state_e;

  typedef struct packed {
    logic [3:0]  ld_st_type;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_id_t;

endpackage

// File: rtl/mem_lsu_stage_load_align.sv
// Byte/half/word selection and sign/zero extension of a load word.
// Combinational; addr picks the lane inside the 32-bit word.
module load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [3:0]  ld_st_type,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{addr, 3'b000} +: 8];
    h      = addr[1] ? word[31:16] : word[15:0];
    result = word;
    unique case (1'b1)
      (ld_st_type == LST_LB):  result = {{24{b[7]}}, b};
      (ld_st_type == LST_LBU): result = {24'd0, b};
      (ld_st_type == LST_LH):  result = {{16{h[15]}}, h};
      (ld_st_type == LST_LHU): result = {16'd0, h};
      default:                 result = word;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM stage: EX->MEM register, data-SRAM wait FSM, load extraction.
// Optional MEM_LSU_ADDR_CHECK_EN adds mem_addr_err for misaligned LH/LW.
module mem_lsu_stage
  import mem_lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_data_ok,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id,
  output logic                    stallreq_from_mem,
  output logic                    mem_is_load
`ifdef MEM_LSU_ADDR_CHECK_EN
  ,
  output logic                    mem_addr_err
`endif
);

  ex_mem_t     r;
  lsu_state_e  state;
  logic [31:0] rbuf;
  logic [31:0] word;
  logic [31:0] ld_data;
  logic        is_load;
  logic        addr_err;
  logic        ld_go;
  logic        mem_stop;
  logic        wb_stop;
  mem_wb_t     wb;
  mem_id_t     fwd;

  assign mem_stop = (stall[STALL_MEM] == STOP);
  assign wb_stop  = (stall[STALL_WB] == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (mem_stop && !wb_stop) begin
      r <= '0;
    end else if (!mem_stop) begin
      r <= ex_mem_t'(ex_to_mem_bus);
    end
  end

  assign is_load = r.ram_en
                 & (r.ram_wen == 4'd0)
                 & r.sel_rf_res;

`ifdef MEM_LSU_ADDR_CHECK_EN
  logic half_op;
  assign half_op  = (r.ld_st_type == LST_LH)
                  | (r.ld_st_type == LST_LHU);
  assign addr_err = (half_op & r.ex_result[0])
                  | ((r.ld_st_type == LST_LW)
                     & (r.ex_result[1:0] != 2'd0));
  assign mem_addr_err = addr_err;
`else
  assign addr_err = 1'b0;
`endif

  // A faulting load never waits on memory.
  assign ld_go = is_load & ~addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LSU_IDLE;
      rbuf  <= '0;
    end else begin
      unique case (state)
        LSU_IDLE: begin
          if (ld_go) begin
            if (!data_sram_data_ok) begin
              state <= LSU_WAIT;
            end else if (mem_stop) begin
              state <= LSU_HOLD;
              rbuf  <= data_sram_rdata;
            end
          end
        end
        LSU_WAIT: begin
          if (data_sram_data_ok) begin
            if (mem_stop) begin
              state <= LSU_HOLD;
              rbuf  <= data_sram_rdata;
            end else begin
              state <= LSU_IDLE;
            end
          end
        end
        LSU_HOLD: begin
          if (!mem_stop) state <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  assign stallreq_from_mem = ld_go
                           & ~data_sram_data_ok
                           & (state != LSU_HOLD);
  assign mem_is_load = is_load;

  assign word = (state == LSU_HOLD) ? rbuf
                                    : data_sram_rdata;

  load_align u_align (
    .word       (word),
    .addr       (r.ex_result[1:0]),
    .ld_st_type (r.ld_st_type),
    .result     (ld_data)
  );

  always_comb begin
    wb.pc       = r.pc;
    wb.rf_we    = r.rf_we & ~addr_err;
    wb.rf_waddr = r.rf_waddr;
    wb.rf_wdata = r.sel_rf_res ? ld_data
                               : r.ex_result;
    fwd.rf_we    = wb.rf_we;
    fwd.rf_waddr = wb.rf_waddr;
    fwd.rf_wdata = wb.rf_wdata;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_id     = fwd;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: directed scenarios plus a
// randomized run against a "load data obtained" reference model.
module tb_mem_lsu_stage;

  localparam logic [3:0] T_NONE = 4'b0000;
  localparam logic [3:0] T_LB   = 4'b0001;
  localparam logic [3:0] T_LBU  = 4'b0010;
  localparam logic [3:0] T_LH   = 4'b0011;
  localparam logic [3:0] T_LHU  = 4'b0100;
  localparam logic [3:0] T_SB   = 4'b0101;
  localparam logic [3:0] T_LW   = 4'b0110;
  localparam logic [3:0] T_SH   = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [5:0]  ext_stall;
  logic [79:0] ex_bus;
  logic [31:0] rdata;
  logic        data_ok;
  logic [69:0] wb;
  logic [37:0] id;
  logic        sreq;
  logic        is_ld;
`ifdef MEM_LSU_ADDR_CHECK_EN
  logic        aerr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stall controller stand-in: a MEM request freezes stages 0..4.
  assign stall = ext_stall | (sreq ? 6'b011111 : 6'b000000);

  mem_lsu_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .ex_to_mem_bus     (ex_bus),
    .data_sram_rdata   (rdata),
    .data_sram_data_ok (data_ok),
    .mem_to_wb_bus     (wb),
    .mem_to_id         (id),
    .stallreq_from_mem (sreq),
    .mem_is_load       (is_ld)
`ifdef MEM_LSU_ADDR_CHECK_EN
    ,
    .mem_addr_err      (aerr)
`endif
  );

  function automatic logic [79:0] mk(
    input logic [3:0]  t,
    input logic [31:0] pc,
    input logic        en,
    input logic [3:0]  wen,
    input logic        sel,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] res
  );
    return {t, pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [79:0] mk_ld(
    input logic [3:0]  t,
    input logic [31:0] addr,
    input logic [4:0]  wa
  );
    return mk(t, 32'h0000_1000, 1'b1, 4'd0,
              1'b1, 1'b1, wa, addr);
  endfunction

  // Reference model: the held instruction and whether its load data
  // has already been obtained while the stage was frozen.
  logic [79:0] m_ins;
  logic        m_have;
  logic [31:0] m_saved;

  function automatic logic [31:0] ref_ext(
    input logic [3:0]  t,
    input logic [31:0] w,
    input logic [1:0]  a
  );
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (t)
      T_LB:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      T_LBU:   return b;
      T_LH:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      T_LHU:   return h;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_err(input logic [79:0] ins);
`ifdef MEM_LSU_ADDR_CHECK_EN
    logic [3:0] t;
    logic [1:0] a;
    t = ins[79:76];
    a = ins[1:0];
    return ((t == T_LH || t == T_LHU) && a[0])
        || (t == T_LW && a != 2'd0);
`else
    return ins[0] & 1'b0;
`endif
  endfunction

  function automatic logic ref_is_load(input logic [79:0] ins);
    return ins[43] && (ins[42:39] == 4'd0) && ins[38];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ins   <= '0;
      m_have  <= 1'b0;
      m_saved <= '0;
    end else begin
      if (ref_is_load(m_ins) && !ref_err(m_ins) && data_ok
          && stall[3] && !m_have) begin
        m_have  <= 1'b1;
        m_saved <= rdata;
      end else if (!stall[3]) begin
        m_have <= 1'b0;
      end
      if (stall[3] && !stall[4]) m_ins <= '0;
      else if (!stall[3]) m_ins <= ex_bus;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    ext_stall = 6'd0;
    data_ok = 1'b0;
    rdata = 32'hFFFF_FFFF;
    ex_bus = mk_ld(T_LW, 32'h100, 5'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (wb !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_wb got %h exp 0", wb);
    end
    n_tests++;
    if (id !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_id got %h exp 0", id);
    end
    n_tests++;
    if (sreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sreq got %b exp 0", sreq);
    end
    n_tests++;
    if (is_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_is_load got %b exp 0", is_ld);
    end
    ex_bus = '0;
    rst = 1'b0;
  endtask

  task automatic test_lw_late();
    int stalls;
    @(negedge clk);
    ex_bus = mk_ld(T_LW, 32'h100, 5'd7);
    data_ok = 1'b0;
    ext_stall = 6'd0;
    @(negedge clk);
    ex_bus = '0;
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (sreq === 1'b1) stalls++;
      @(negedge clk);
    end
    data_ok = 1'b1;
    rdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (stalls != 2 || sreq !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_stall_cycles got %0d/%b exp 2/0",
               stalls, sreq);
    end
    n_tests++;
    if (wb[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL lw_wdata got %h exp deadbeef", wb[31:0]);
    end
    n_tests++;
    if (wb[37] !== 1'b1 || id[37] !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_we got %b/%b exp 1/1", wb[37], id[37]);
    end
    @(negedge clk);
    data_ok = 1'b0;
    #1;
    n_tests++;
    if (sreq !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_after_sreq got %b exp 0", sreq);
    end
  endtask

  task automatic test_byte_half();
    @(negedge clk);
    ex_bus = mk_ld(T_LB, 32'h103, 5'd2);
    data_ok = 1'b0;
    @(negedge clk);
    ex_bus = mk_ld(T_LBU, 32'h103, 5'd2);
    data_ok = 1'b1;
    rdata = 32'h8011_2233;
    #1;
    n_tests++;
    if (wb[31:0] !== 32'hFFFF_FF80 || sreq !== 1'b0) begin
      n_fail++;
      $display("FAIL lb got %h exp ffffff80", wb[31:0]);
    end
    @(negedge clk);
    ex_bus = mk_ld(T_LH, 32'h102, 5'd3);
    #1;
    n_tests++;
    if (wb[31:0] !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu got %h exp 00000080", wb[31:0]);
    end
    @(negedge clk);
    ex_bus = mk_ld(T_LHU, 32'h100, 5'd4);
    rdata = 32'h9ABC_1234;
    #1;
    n_tests++;
    if (wb[31:0] !== 32'hFFFF_9ABC) begin
      n_fail++;
      $display("FAIL lh got %h exp ffff9abc", wb[31:0]);
    end
    @(negedge clk);
    ex_bus = '0;
    #1;
    n_tests++;
    if (id[31:0] !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL lhu got %h exp 00001234", id[31:0]);
    end
    @(negedge clk);
    data_ok = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    ex_bus = mk_ld(T_LW, 32'h200, 5'd9);
    data_ok = 1'b0;
    ext_stall = 6'd0;
    @(negedge clk);
    ex_bus = '0;
    @(negedge clk);
    data_ok = 1'b1;
    rdata = 32'h1234_5678;
    ext_stall = 6'b011111;
    @(negedge clk);
    data_ok = 1'b0;
    rdata = 32'h0;
    #1;
    n_tests++;
    if (wb[31:0] !== 32'h1234_5678 || sreq !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_wdata got %h/%b exp 12345678/0",
               wb[31:0], sreq);
    end
    @(negedge clk);
    ext_stall = 6'd0;
    #1;
    n_tests++;
    if (wb[31:0] !== 32'h1234_5678 || wb[37] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release got %h exp 12345678", wb[31:0]);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (wb !== 70'd0) begin
      n_fail++;
      $display("FAIL hold_next got %h exp 0", wb);
    end
  endtask

  task automatic test_bubble();
    @(negedge clk);
    ex_bus = mk(T_NONE, 32'h3000, 1'b0, 4'd0, 1'b0,
                1'b1, 5'd3, 32'hCAFE_0001);
    ext_stall = 6'd0;
    @(negedge clk);
    ext_stall = 6'b001000;
    #1;
    n_tests++;
    if (wb[37] !== 1'b1 || wb[31:0] !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL alu_pass got %h exp cafe0001", wb[31:0]);
    end
    @(negedge clk);
    ext_stall = 6'd0;
    ex_bus = '0;
    #1;
    n_tests++;
    if (wb !== 70'd0 || id !== 38'd0) begin
      n_fail++;
      $display("FAIL bubble got %h/%h exp 0/0", wb, id);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    ex_bus = mk(T_SB, 32'h4000, 1'b1, 4'b0001, 1'b0,
                1'b0, 5'd0, 32'h0000_0404);
    @(negedge clk);
    ex_bus = '0;
    data_ok = 1'b1;
    rdata = 32'h5555_5555;
    #1;
    n_tests++;
    if (sreq !== 1'b0 || is_ld !== 1'b0
        || wb[31:0] !== 32'h0000_0404) begin
      n_fail++;
      $display("FAIL store got %b/%b/%h exp 0/0/00000404",
               sreq, is_ld, wb[31:0]);
    end
    @(negedge clk);
    data_ok = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    ex_bus = mk_ld(T_LW, 32'h300, 5'd5);
    data_ok = 1'b0;
    ext_stall = 6'd0;
    @(negedge clk);
    ex_bus = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (sreq !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_sreq got %b exp 1", sreq);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (sreq !== 1'b0 || wb !== 70'd0 || is_ld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_wait got %b/%h exp 0/0", sreq, wb);
    end
  endtask

`ifdef MEM_LSU_ADDR_CHECK_EN
  task automatic test_addr_err();
    @(negedge clk);
    ex_bus = mk_ld(T_LW, 32'h102, 5'd6);
    data_ok = 1'b0;
    ext_stall = 6'd0;
    @(negedge clk);
    ex_bus = mk_ld(T_LW, 32'h100, 5'd6);
    #1;
    n_tests++;
    if (aerr !== 1'b1 || wb[37] !== 1'b0
        || id[37] !== 1'b0 || sreq !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_err got %b/%b/%b/%b exp 1/0/0/0",
               aerr, wb[37], id[37], sreq);
    end
    @(negedge clk);
    ex_bus = '0;
    data_ok = 1'b1;
    #1;
    n_tests++;
    if (aerr !== 1'b0 || wb[37] !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_ok got %b/%b exp 0/1", aerr, wb[37]);
    end
    @(negedge clk);
    data_ok = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [3:0]  lt [5];
    logic [31:0] w;
    logic [31:0] wd;
    logic [69:0] e_wb;
    logic        e_sreq;
    logic        e_we;
    logic        lok;
    int          r;
    lt = '{T_LB, T_LBU, T_LH, T_LHU, T_LW};
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      r = $urandom % 10;
      ext_stall = (r < 7) ? 6'd0
                : (r < 9) ? 6'b011111 : 6'b001000;
      case ($urandom % 4)
        0, 1: ex_bus = mk_ld(lt[$urandom % 5], $urandom,
                             5'($urandom));
        2: ex_bus = mk(($urandom % 2) ? T_SB : T_SH, $urandom,
                       1'b1, 4'($urandom_range(1, 15)), 1'b0,
                       1'b0, 5'($urandom), $urandom);
        default: ex_bus = mk(T_NONE, $urandom, 1'b0, 4'd0,
                             1'b0, 1'($urandom), 5'($urandom),
                             $urandom);
      endcase
      rdata = $urandom;
      lok = ref_is_load(m_ins) && !ref_err(m_ins) && !m_have;
      data_ok = lok ? (($urandom % 3) == 0)
                    : (($urandom % 4) == 0);
      #1;
      w  = m_have ? m_saved : rdata;
      wd = m_ins[38] ? ref_ext(m_ins[79:76], w, m_ins[1:0])
                     : m_ins[31:0];
      e_we   = m_ins[37] && !ref_err(m_ins);
      e_wb   = {m_ins[75:44], e_we, m_ins[36:32], wd};
      e_sreq = lok && !data_ok;
      n_tests++;
      if (wb !== e_wb) begin
        n_fail++;
        $display("FAIL rand_wb i=%0d got %h exp %h", i, wb, e_wb);
      end
      n_tests++;
      if (id !== e_wb[37:0]) begin
        n_fail++;
        $display("FAIL rand_id i=%0d got %h exp %h",
                 i, id, e_wb[37:0]);
      end
      n_tests++;
      if (sreq !== e_sreq) begin
        n_fail++;
        $display("FAIL rand_sreq i=%0d got %b exp %b",
                 i, sreq, e_sreq);
      end
      n_tests++;
      if (is_ld !== ref_is_load(m_ins)) begin
        n_fail++;
        $display("FAIL rand_is_load i=%0d got %b exp %b",
                 i, is_ld, ref_is_load(m_ins));
      end
`ifdef MEM_LSU_ADDR_CHECK_EN
      n_tests++;
      if (aerr !== ref_err(m_ins)) begin
        n_fail++;
        $display("FAIL rand_aerr i=%0d got %b exp %b",
                 i, aerr, ref_err(m_ins));
      end
`endif
    end
    @(negedge clk);
    ext_stall = 6'd0;
    data_ok = 1'b0;
    ex_bus = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_late();
    test_byte_half();
    test_hold();
    test_bubble();
    test_store();
    test_reset_mid_wait();
`ifdef MEM_LSU_ADDR_CHECK_EN
    test_addr_err();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
